dotp_alu_sequencer: RTL and testbench
=====================================

# dotp_alu_sequencer

Sequencing front end that drives the combinational 24-bit ALU to compute a dot product over a stream of operand pairs. Each pair is fetched over a valid/ready handshake and multiplied; the product is optionally rescaled to Q8 fixed point and then accumulated, with every operation issued through the ALU's opcode/operand/result interface. The block sits between the matrix-multiplication control path, which supplies `start`, `len` and operand pairs, and the ALU. It yields one matrix element per run.

## Interface
- `DATA_W`, 24: operand, accumulator and ALU width.
- `LEN_W`, 8: width of the pair-count input.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; latched on an accepted `start`.
- `a_data`  in  DATA_W  operand A of the current pair.
- `b_data`  in  DATA_W  operand B of the current pair.
- `op_valid`  in  1  the pair on `a_data`/`b_data` is valid.
- `op_ready`  out  1  sequencer accepts a pair this cycle.
- `alu_ctrl`  out  3  ALU opcode: 0 ADD, 1 MUL, 2 SUB, 3 SFTR, 4 SFTL.
- `alu_a`  out  DATA_W  ALU operand A.
- `alu_b`  out  DATA_W  ALU operand B.
- `alu_c`  in  DATA_W  ALU result (combinational).
- `alu_z`  in  1  ALU zero flag.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, high in the FIN state.
- `result`  out  DATA_W  dot product; held until the next FIN.
- `result_zero`  out  1  `result` == 0.

## Operation
- States: IDLE, FETCH, MUL, SCALE (present only with the macro), ACC, FIN.
- IDLE
  - `start`=1 latches `len` into `cnt` and clears `acc`.
  - `len`≠0: go to FETCH.
  - `len`=0: go to FIN; `result` is loaded with 0 and `result_zero` with 1.
- FETCH
  - `op_ready`=1.
  - On `op_valid`&`op_ready`: latch `a_data`/`b_data` into `a_r`/`b_r` and go to MUL.
  - Otherwise stay in FETCH.
- MUL: drive `alu_ctrl`=1, `alu_a`=`a_r`, `alu_b`=`b_r`; `prod`<=`alu_c`; go to SCALE (if configured) or ACC.
- SCALE: drive `alu_ctrl`=3, `alu_a`=`prod`; `prod`<=`alu_c`; go to ACC.
- ACC
  - Drive `alu_ctrl`=0, `alu_a`=`acc`, `alu_b`=`prod`.
  - `acc`<=`alu_c`; `cnt`<=`cnt`-1.
  - `cnt`==1: load `result`<=`alu_c` and `result_zero`<=`alu_z`, then go to FIN.
  - Otherwise go to FETCH.
- FIN: `done`=1; go to IDLE unconditionally.
- In IDLE, FETCH and FIN the ALU inputs are idle: `alu_ctrl`=0, `alu_a`=0, `alu_b`=0.
- All arithmetic is modulo 2^DATA_W and is performed by the ALU. The sequencer never widens, saturates or sign-extends values.
- `start` outside IDLE is ignored; `len` is not re-latched.
- `op_valid` outside FETCH is ignored; `a_data`/`b_data` need not be held stable.

## Timing
- Reset values: `op_ready`=0, `busy`=0, `done`=0, `result`=0, `result_zero`=1, `alu_ctrl`=0, `alu_a`=0, `alu_b`=0. All internal registers are 0 and the state is IDLE.
- Reset is asynchronous. Asserting it mid-run aborts the run immediately with no `done` pulse.
- Cycle numbering: `start` is accepted at edge 0, and `op_valid` is held high.
- Without SCALE, pair k (0-based) occupies:
  - FETCH at cycle 1+3k
  - MUL at 2+3k
  - ACC at 3+3k
  - FIN, with `done`=1, at cycle 3·len+1.
- With SCALE the per-pair period is 4 cycles and FIN falls at 4·len+1.
- `len`=0: FIN at cycle 1.
- Each cycle `op_valid` is low during FETCH delays all later events by one cycle.
- `result` and `result_zero` change only on entry to FIN, so they are valid in the same cycle as `done`.
- Next `start` accepted: the cycle after FIN (IDLE), at the earliest.

## Configuration
- `DOTP_SCALE_EN` defined
  - The SCALE state is compiled in.
  - Each product is shifted right by 8, so Q8×Q8 products are rescaled to Q8 before accumulation.
- Undefined
  - SCALE is absent; MUL goes directly to ACC.
  - Results are plain integer dot products mod 2^24.

## Test plan
- Integer run, no macro: `len`=3, pairs (2,3),(4,5),(1,1) with `op_valid` held high -> `done` at cycle 10, `result`=27, `result_zero`=0.
- `len`=0 -> `done` at cycle 1, `result`=0, `result_zero`=1, `op_ready` never asserted.
- Backpressure: the same three pairs with `op_valid` low for 5 cycles before pair 1 -> `op_ready` stays high throughout the gap, `result`=27, `done` at cycle 15.
- Wrap-around, no macro: `len`=1, pair (0x1000,0x1000) -> `result`=0x000000, `result_zero`=1.
- Scaling with `DOTP_SCALE_EN`: `len`=2, pairs (0x200,0x300),(0x100,0x080) -> `alu_ctrl` sequence 1,3,0 per pair, `result`=0x680, `done` at cycle 9.
- Reset and ignored `start`:
  - Pulse `start` during MUL -> ignored; the run completes normally.
  - Drop `reset_n` during ACC -> `busy`, `done` and `result` are 0 in the same cycle.
  - A fresh run after reset gives the correct result.

Source files
------------

// File: rtl/dotp_alu_sequencer.sv
// Dot-product sequencer: fetches operand pairs and drives an external combinational ALU
// through multiply, optional Q8 rescale (`define DOTP_SCALE_EN) and accumulate steps.
module dotp_alu_sequencer #(
    parameter int DATA_W = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic              op_valid,
    output logic              op_ready,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_z,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              result_zero
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_SFTR = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL,
`ifdef DOTP_SCALE_EN
        S_SCALE,
`endif
        S_ACC,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_zero_q, result_zero_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            prod_q        <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            a_q           <= a_d;
            b_q           <= b_d;
            prod_q        <= prod_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        a_d           = a_q;
        b_d           = b_q;
        prod_d        = prod_q;
        result_d      = result_q;
        result_zero_d = result_zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = len;
                    acc_d = '0;
                    // An empty run still completes, reporting a zero result.
                    if (len == '0) begin
                        result_d      = '0;
                        result_zero_d = 1'b1;
                        state_d       = S_FIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (op_valid) begin
                    a_d     = a_data;
                    b_d     = b_data;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                prod_d = alu_c;
`ifdef DOTP_SCALE_EN
                state_d = S_SCALE;
`else
                state_d = S_ACC;
`endif
            end
`ifdef DOTP_SCALE_EN
            S_SCALE: begin
                prod_d  = alu_c;
                state_d = S_ACC;
            end
`endif
            S_ACC: begin
                acc_d = alu_c;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    result_d      = alu_c;
                    result_zero_d = alu_z;
                    state_d       = S_FIN;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        op_ready = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        alu_ctrl = OP_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state_q)
            S_FETCH: op_ready = 1'b1;
            S_MUL: begin
                alu_ctrl = OP_MUL;
                alu_a    = a_q;
                alu_b    = b_q;
            end
`ifdef DOTP_SCALE_EN
            // Q8 x Q8 gives Q16; shifting right by 8 returns to Q8.
            S_SCALE: begin
                alu_ctrl = OP_SFTR;
                alu_a    = prod_q;
                alu_b    = DATA_W'(8);
            end
`endif
            S_ACC: begin
                alu_ctrl = OP_ADD;
                alu_a    = acc_q;
                alu_b    = prod_q;
            end
            S_FIN: done = 1'b1;
            default: begin
            end
        endcase
    end

    assign result      = result_q;
    assign result_zero = result_zero_q;

endmodule

// File: tb/tb_dotp_alu_sequencer.sv
// Self-checking bench for dotp_alu_sequencer: models the ALU, runs a vector table,
// randomized runs against a reference dot-product model, and reset/abort sequences.
module tb_dotp_alu_sequencer;

    localparam int DATA_W = 24;
    localparam int LEN_W  = 8;
`ifdef DOTP_SCALE_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 3;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_c;
    logic              alu_z;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              result_zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]        len;
        logic [3:0][23:0]  a;
        logic [3:0][23:0]  b;
        logic [3:0][7:0]   gap;
        logic              poke;
        logic [23:0]       exp_res;
        logic              exp_z;
        logic [31:0]       exp_done;
    } vec_t;

    vec_t vecs[$];

    dotp_alu_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .len         (len),
        .a_data      (a_data),
        .b_data      (b_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_zero (result_zero)
    );

    always #5 clk = ~clk;

    // Combinational 24-bit ALU the sequencer drives.
    always_comb begin
        case (alu_ctrl)
            3'd0:    alu_c = alu_a + alu_b;
            3'd1:    alu_c = alu_a * alu_b;
            3'd2:    alu_c = alu_a - alu_b;
            3'd3:    alu_c = alu_a >> alu_b;
            3'd4:    alu_c = alu_a << alu_b;
            default: alu_c = '0;
        endcase
    end
    assign alu_z = (alu_c == '0);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] refDot(input vec_t v);
        longint unsigned acc = 0;
        longint unsigned p;
        for (int i = 0; i < int'(v.len); i++) begin
            p = (longint'(v.a[i]) * longint'(v.b[i])) % 64'h1000000;
`ifdef DOTP_SCALE_EN
            p = p / 256;
`endif
            acc = (acc + p) % 64'h1000000;
        end
        return acc[23:0];
    endfunction

    function automatic vec_t mkVec(input logic [7:0] l, input logic [3:0][23:0] a,
                                   input logic [3:0][23:0] b, input logic [3:0][7:0] g,
                                   input logic poke, input logic [23:0] res,
                                   input logic z, input logic [31:0] dn);
        vec_t v;
        v.len = l; v.a = a; v.b = b; v.gap = g; v.poke = poke;
        v.exp_res = res; v.exp_z = z; v.exp_done = dn;
        return v;
    endfunction

    // Runs one dot product; data are only offered while op_ready is seen high.
    task automatic applyStimulus(input vec_t v);
        int pidx = 0;
        int midx = 0;
        int gap;
        int done_cyc = -1;
        bit seen_ready = 0;
        bit poked = 0;
        bit ok;
        logic [2:0] ctrl_seen[$];
        logic [2:0] ctrl_exp[$];
        @(negedge clk);
        start    = 1'b1;
        len      = v.len;
        op_valid = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        gap = int'(v.gap[0]);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (op_ready) begin
                seen_ready = 1;
                if (gap > 0) begin
                    op_valid = 1'b0;
                    gap--;
                end else begin
                    op_valid = 1'b1;
                    a_data   = v.a[pidx[1:0]];
                    b_data   = v.b[pidx[1:0]];
                    pidx++;
                    gap = (pidx < 4) ? int'(v.gap[pidx[1:0]]) : 0;
                end
            end else begin
                op_valid = 1'($urandom_range(0, 1));
                a_data   = 24'($urandom);
                b_data   = 24'($urandom);
                if (busy) ctrl_seen.push_back(alu_ctrl);
                if (busy && alu_ctrl == 3'd1) begin
                    checkOutput("mul operand a", 32'(alu_a), 32'(v.a[midx[1:0]]));
                    checkOutput("mul operand b", 32'(alu_b), 32'(v.b[midx[1:0]]));
                    midx++;
                    if (v.poke && !poked) begin
                        start = 1'b1;
                        len   = 8'd7;
                        poked = 1;
                    end
                end
            end
        end
        op_valid = 1'b0;
        start    = 1'b0;
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout: no done within 200 cycles, len=%0d", v.len);
        end else begin
            checkOutput("done cycle", 32'(done_cyc), v.exp_done);
            checkOutput("result", 32'(result), 32'(v.exp_res));
            checkOutput("result_zero", 32'(result_zero), 32'(v.exp_z));
            checkOutput("op_ready seen", 32'(seen_ready), 32'(v.len != 0));
            for (int i = 0; i < int'(v.len); i++) begin
                ctrl_exp.push_back(3'd1);
`ifdef DOTP_SCALE_EN
                ctrl_exp.push_back(3'd3);
`endif
                ctrl_exp.push_back(3'd0);
            end
            ok = (ctrl_seen.size() == ctrl_exp.size());
            if (ok) foreach (ctrl_exp[i]) if (ctrl_seen[i] !== ctrl_exp[i]) ok = 0;
            checkOutput("alu_ctrl sequence", 32'(ok), 32'd1);
            @(negedge clk);
            checkOutput("idle after fin", {30'd0, done, busy}, 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        int gsum;
        reset_n  = 1'b0;
        start    = 1'b0;
        len      = '0;
        a_data   = '0;
        b_data   = '0;
        op_valid = 1'b0;

`ifndef DOTP_SCALE_EN
        vecs.push_back(mkVec(8'd3, {24'd0, 24'd1, 24'd4, 24'd2}, {24'd0, 24'd1, 24'd5, 24'd3},
                             '0, 1'b0, 24'd27, 1'b0, 32'd10));
        vecs.push_back(mkVec(8'd0, '0, '0, '0, 1'b0, 24'd0, 1'b1, 32'd1));
        vecs.push_back(mkVec(8'd3, {24'd0, 24'd1, 24'd4, 24'd2}, {24'd0, 24'd1, 24'd5, 24'd3},
                             {8'd0, 8'd0, 8'd5, 8'd0}, 1'b0, 24'd27, 1'b0, 32'd15));
        vecs.push_back(mkVec(8'd1, {72'd0, 24'h1000}, {72'd0, 24'h1000},
                             '0, 1'b0, 24'h000000, 1'b1, 32'd4));
        vecs.push_back(mkVec(8'd3, {24'd0, 24'd1, 24'd4, 24'd2}, {24'd0, 24'd1, 24'd5, 24'd3},
                             '0, 1'b1, 24'd27, 1'b0, 32'd10));
        vecs.push_back(mkVec(8'd2, {48'd0, 24'd1, 24'hFFFFFF}, {48'd0, 24'd1, 24'd1},
                             '0, 1'b0, 24'd0, 1'b1, 32'd7));
`else
        vecs.push_back(mkVec(8'd2, {48'd0, 24'h100, 24'h200}, {48'd0, 24'h080, 24'h300},
                             '0, 1'b0, 24'h680, 1'b0, 32'd9));
        vecs.push_back(mkVec(8'd0, '0, '0, '0, 1'b0, 24'd0, 1'b1, 32'd1));
        vecs.push_back(mkVec(8'd1, {72'd0, 24'h10}, {72'd0, 24'h10},
                             '0, 1'b1, 24'd1, 1'b0, 32'd5));
`endif

        #12;
        checkOutput("reset op_ready", 32'(op_ready), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset result_zero", 32'(result_zero), 32'd1);
        checkOutput("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("reset alu_a", 32'(alu_a), 32'd0);
        checkOutput("reset alu_b", 32'(alu_b), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        for (int r = 0; r < 8; r++) begin
            v = '0;
            v.len = 8'($urandom_range(1, 4));
            gsum = 0;
            for (int i = 0; i < 4; i++) begin
                v.a[i]   = (r < 4) ? 24'($urandom_range(0, 4095)) : 24'($urandom);
                v.b[i]   = (r < 4) ? 24'($urandom_range(0, 4095)) : 24'($urandom);
                v.gap[i] = 8'($urandom_range(0, 2));
                if (i < int'(v.len)) gsum += int'(v.gap[i]);
            end
            v.poke     = 1'($urandom_range(0, 1));
            v.exp_res  = refDot(v);
            v.exp_z    = (v.exp_res == 24'd0);
            v.exp_done = 32'(PERIOD * int'(v.len) + 1 + gsum);
            applyStimulus(v);
        end

        // Leave a non-zero result behind, then abort a run in its first ACC cycle.
        applyStimulus(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        len   = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        op_valid = 1'b1;
        a_data   = 24'd2;
        b_data   = 24'd3;
        begin
            bit found = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (busy && !op_ready && !done && alu_ctrl == 3'd0) begin
                    found = 1;
                    break;
                end
            end
            if (!found) begin
                checks++;
                errors++;
                $display("[TB] FAIL acc wait: ACC state not reached within 50 cycles");
            end
        end
        reset_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort result", 32'(result), 32'd0);
        checkOutput("abort op_ready", 32'(op_ready), 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
